// File: rtl/dsp_core_pkg.sv
// ============================================================================
// dsp_core_pkg : shared opcodes, FSM states and instruction field positions
// Rev 1.0
// ============================================================================
`default_nettype none

package dsp_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JN   = 4'hA;
  localparam logic [3:0] OP_END  = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int RS_MSB  = 23;
  localparam int RS_LSB  = 20;
  localparam int IMM_MSB = 19;
  localparam int IMM_LSB = 0;
  localparam int RIDX_W  = 4;

endpackage

`default_nettype wire

// File: rtl/dsp_regfile.sv
// ============================================================================
// dsp_regfile : 2 async read / 1 sync write register file, R0 reads as zero
// Rev 1.0
// ============================================================================
`default_nettype none

module dsp_regfile
  import dsp_core_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int REG_W = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] waddr_i,
  input  logic [REG_W-1:0]  wdata_i,
  input  logic [RIDX_W-1:0] raddr_a_i,
  output logic [REG_W-1:0]  rdata_a_o,
  input  logic [RIDX_W-1:0] raddr_b_i,
  output logic [REG_W-1:0]  rdata_b_o
);

  localparam int IDX_W = $clog2(NREG);

  logic [REG_W-1:0] regs_q [NREG];

  // Index 0 and indices beyond NREG behave as a constant-zero register.
  function automatic logic idx_ok(input logic [RIDX_W-1:0] idx);
    return (idx != '0) && (int'(idx) < NREG);
  endfunction

  assign rdata_a_o = idx_ok(raddr_a_i) ? regs_q[raddr_a_i[IDX_W-1:0]] : '0;
  assign rdata_b_o = idx_ok(raddr_b_i) ? regs_q[raddr_b_i[IDX_W-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && idx_ok(waddr_i)) begin
      regs_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_dsp_core.sv
// ============================================================================
// param_dsp_core : multi-cycle downsampling core with req/ack IM and DM ports
// Rev 1.0
// ============================================================================
`default_nettype none

module param_dsp_core
  import dsp_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 20,
  parameter int PC_W   = 10,
  parameter int REG_W  = 32,
  parameter int NREG   = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              err,
  output logic              im_req,
  output logic [PC_W-1:0]   im_addr,
  input  logic              im_ack,
  input  logic [31:0]       im_rdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [PC_W-1:0]   dbg_pc,
  output logic              dbg_z,
  output logic              dbg_n
);

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [31:0]         ir_q;
  logic                done_q, err_q, im_req_q, dm_req_q, dm_we_q, z_q, n_q;
  logic [ADDR_W-1:0]   dm_addr_q;
  logic [DATA_W-1:0]   dm_wdata_q;

  logic [3:0]          opc;
  logic [RIDX_W-1:0]   rd_idx, rs_idx;
  logic [19:0]         imm;
  logic [REG_W-1:0]    rd_val, rs_val, alu_d, rf_wdata_d;
  logic                alu_we_d, rf_we_d;
  logic [PC_W-1:0]     pc_inc_d;

  assign opc      = ir_q[OPC_MSB:OPC_LSB];
  assign rd_idx   = ir_q[RD_MSB:RD_LSB];
  assign rs_idx   = ir_q[RS_MSB:RS_LSB];
  assign imm      = ir_q[IMM_MSB:IMM_LSB];
  assign pc_inc_d = pc_q + 1'b1;

  always_comb begin
    alu_d    = '0;
    alu_we_d = 1'b0;
    case (opc)
      OP_LDI:  begin alu_d = REG_W'(imm);             alu_we_d = 1'b1; end
      OP_ADD:  begin alu_d = rd_val + rs_val;         alu_we_d = 1'b1; end
      OP_SUB:  begin alu_d = rd_val - rs_val;         alu_we_d = 1'b1; end
      OP_SHR:  begin alu_d = rd_val >> imm[4:0];      alu_we_d = 1'b1; end
      OP_ADDI: begin alu_d = rd_val + REG_W'(imm);    alu_we_d = 1'b1; end
      default: ;
    endcase
  end

  // Write port is shared by EXEC-stage results and LD data returning in MEM.
  assign rf_we_d    = ((state_q == ST_EXEC) && alu_we_d) ||
                      ((state_q == ST_MEM) && dm_ack && !dm_we_q);
  assign rf_wdata_d = (state_q == ST_MEM) ? REG_W'(dm_rdata) : alu_d;

  dsp_regfile #(
    .NREG  (NREG),
    .REG_W (REG_W)
  ) u_regfile (
    .clock     (clock),
    .rst       (rst),
    .we_i      (rf_we_d),
    .waddr_i   (rd_idx),
    .wdata_i   (rf_wdata_d),
    .raddr_a_i (rd_idx),
    .rdata_a_o (rd_val),
    .raddr_b_i (rs_idx),
    .rdata_b_o (rs_val)
  );

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      im_req_q   <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            im_req_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (im_ack) begin
            ir_q     <= im_rdata;
            im_req_q <= 1'b0;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q  <= ST_FETCH;
          im_req_q <= 1'b1;
          pc_q     <= pc_inc_d;
          case (opc)
            OP_NOP, OP_LDI: ;
            OP_ADD, OP_SUB, OP_SHR, OP_ADDI: begin
              z_q <= (alu_d == '0);
              n_q <= alu_d[REG_W-1];
            end
            OP_JMP: pc_q <= PC_W'(imm);
            OP_JZ:  if (rd_val == '0) pc_q <= PC_W'(imm);
            OP_JN:  if (rd_val[REG_W-1]) pc_q <= PC_W'(imm);
            OP_LD, OP_ST: begin
              state_q   <= ST_MEM;
              im_req_q  <= 1'b0;
              pc_q      <= pc_q;
              dm_req_q  <= 1'b1;
              dm_we_q   <= (opc == OP_ST);
              dm_addr_q <= rs_val[ADDR_W-1:0];
              if (opc == OP_ST) dm_wdata_q <= rd_val[DATA_W-1:0];
            end
            OP_END: begin
              state_q  <= ST_HALT;
              im_req_q <= 1'b0;
              pc_q     <= pc_q;
              done_q   <= 1'b1;
            end
            default: begin
              state_q  <= ST_HALT;
              im_req_q <= 1'b0;
              pc_q     <= pc_q;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          if (dm_ack) begin
            dm_req_q <= 1'b0;
            dm_we_q  <= 1'b0;
            pc_q     <= pc_inc_d;
            im_req_q <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_HALT: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign im_req   = im_req_q;
  assign im_addr  = pc_q;
  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign dbg_pc   = pc_q;
  assign dbg_z    = z_q;
  assign dbg_n    = n_q;

endmodule

`default_nettype wire

// File: tb/tb_param_dsp_core.sv
// ============================================================================
// tb_param_dsp_core : directed and random programs against an ISA-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_param_dsp_core;
  import dsp_core_pkg::*;

  localparam int DATA_W = 8, ADDR_W = 20, PC_W = 10, REG_W = 32, NREG = 8;

  logic              clock = 1'b0, rst = 1'b0, start = 1'b0;
  logic              done, err, im_req, im_ack, dm_req, dm_we, dm_ack, dbg_z, dbg_n;
  logic [PC_W-1:0]   im_addr, dbg_pc;
  logic [31:0]       im_rdata;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;

  always #5 clock = ~clock;

  param_dsp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .REG_W(REG_W), .NREG(NREG)) dut (
    .clock(clock), .rst(rst), .start(start), .done(done), .err(err),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dbg_pc(dbg_pc), .dbg_z(dbg_z), .dbg_n(dbg_n)
  );

  typedef struct packed { logic we; logic [19:0] a; logic [7:0] d; } acc_t;

  logic [31:0] imem [1024];
  logic [7:0]  tb_dm [logic [19:0]];
  acc_t        dm_log[$], exp_wr[$];
  int          dm_len_q[$];
  logic [9:0]  fetch_log[$];
  int          im_wait = 0, dm_wait = 0;
  int          n_vec = 0, n_bad = 0;
  logic [9:0]  m_pc;
  logic        m_z, m_n, m_err;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [19:0] im);
    return {op, rd, rs, im};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responders: random or fixed wait states, ack driven mid-cycle.
  initial begin
    int  im_cnt = 0, im_tgt = 0, dm_cnt = 0, dm_tgt = 0, dm_len = 0;
    bit  im_busy = 0, dm_busy = 0;
    acc_t e;
    im_ack = 0; dm_ack = 0; im_rdata = '0; dm_rdata = '0;
    forever begin
      @(negedge clock);
      if (rst && im_req) begin
        if (!im_busy) begin
          im_busy = 1; im_cnt = 0;
          im_tgt = (im_wait < 0) ? int'($urandom_range(0, 3)) : im_wait;
        end
        if (im_cnt >= im_tgt) begin
          im_ack = 1; im_rdata = imem[im_addr]; fetch_log.push_back(im_addr); im_busy = 0;
        end else begin
          im_ack = 0; im_cnt++;
        end
      end else begin
        im_ack = 0; im_busy = 0;
      end
      if (rst && dm_req) begin
        dm_len++;
        if (!dm_busy) begin
          dm_busy = 1; dm_cnt = 0;
          dm_tgt = (dm_wait < 0) ? int'($urandom_range(0, 3)) : dm_wait;
        end
        if (dm_cnt >= dm_tgt) begin
          dm_ack = 1;
          if (dm_we) tb_dm[dm_addr] = dm_wdata;
          else dm_rdata = tb_dm.exists(dm_addr) ? tb_dm[dm_addr] : 8'h00;
          e.we = dm_we; e.a = dm_addr; e.d = dm_we ? dm_wdata : dm_rdata;
          dm_log.push_back(e); dm_len_q.push_back(dm_len);
          dm_len = 0; dm_busy = 0;
        end else begin
          dm_ack = 0; dm_cnt++;
        end
      end else begin
        dm_ack = 0; dm_busy = 0; dm_len = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction-set interpreter: executes the program in imem over a copy of DM.
  task automatic model_run();
    logic [31:0] r [16];
    logic [7:0]  mdm [logic [19:0]];
    logic [31:0] ins, a, b, res;
    logic [3:0]  op, rd, rs;
    logic [19:0] im;
    logic [9:0]  pc, npc;
    acc_t        e;
    mdm = tb_dm;
    for (int i = 0; i < 16; i++) r[i] = 0;
    m_z = 0; m_n = 0; m_err = 0; pc = 0; exp_wr.delete();
    for (int step = 0; step < 4096; step++) begin
      ins = imem[pc];
      op = ins[31:28]; rd = ins[27:24]; rs = ins[23:20]; im = ins[19:0];
      a = (rd != 0 && int'(rd) < NREG) ? r[rd] : 0;
      b = (rs != 0 && int'(rs) < NREG) ? r[rs] : 0;
      if (op == 4'hB) break;
      if (op > 4'hB) begin m_err = 1; break; end
      npc = pc + 10'd1;
      res = 0;
      case (op)
        4'h1: res = {12'b0, im};
        4'h2: res = {24'b0, (mdm.exists(b[19:0]) ? mdm[b[19:0]] : 8'h00)};
        4'h3: begin
          mdm[b[19:0]] = a[7:0];
          e.we = 1; e.a = b[19:0]; e.d = a[7:0]; exp_wr.push_back(e);
        end
        4'h4: res = a + b;
        4'h5: res = a - b;
        4'h6: res = a >> im[4:0];
        4'h7: res = a + {12'b0, im};
        4'h8: npc = im[9:0];
        4'h9: if (a == 0) npc = im[9:0];
        4'hA: if (a[31]) npc = im[9:0];
        default: ;
      endcase
      if (op == 4'h1 || op == 4'h2 || (op >= 4'h4 && op <= 4'h7))
        if (rd != 0 && int'(rd) < NREG) r[rd] = res;
      if (op >= 4'h4 && op <= 4'h7) begin m_z = (res == 0); m_n = res[31]; end
      pc = npc;
    end
    m_pc = pc;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = enc(OP_END, 4'd0, 4'd0, 20'd0);
  endtask

  task automatic clear_logs();
    dm_log.delete(); fetch_log.delete(); dm_len_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock); rst = 0;
    @(posedge clock); @(posedge clock);
    @(negedge clock); rst = 1;
    clear_logs();
  endtask

  task automatic start_and_wait(input int max_cyc, output int cyc);
    @(negedge clock); start = 1;
    @(posedge clock); #1 start = 0;
    cyc = 0;
    while (!done && cyc < max_cyc) begin @(posedge clock); #1; cyc++; end
  endtask

  task automatic run_prog(input string tag, input int max_cyc, input bit with_rst);
    int   cyc;
    acc_t wr[$];
    if (with_rst) do_reset(); else clear_logs();
    model_run();
    start_and_wait(max_cyc, cyc);
    chk($sformatf("%s.done", tag), done, 1);
    chk($sformatf("%s.err", tag), err, m_err);
    chk($sformatf("%s.pc", tag), dbg_pc, m_pc);
    chk($sformatf("%s.z", tag), dbg_z, m_z);
    chk($sformatf("%s.n", tag), dbg_n, m_n);
    foreach (dm_log[i]) if (dm_log[i].we) wr.push_back(dm_log[i]);
    chk($sformatf("%s.nwr", tag), wr.size(), exp_wr.size());
    for (int i = 0; i < wr.size() && i < exp_wr.size(); i++) begin
      chk($sformatf("%s.wa%0d", tag, i), wr[i].a, exp_wr[i].a);
      chk($sformatf("%s.wd%0d", tag, i), wr[i].d, exp_wr[i].d);
    end
  endtask

  initial begin
    int cyc, reqs, k, len;
    logic [3:0] op, rd, rs;
    logic [19:0] im;

    repeat (3) @(posedge clock);
    #1;
    chk("rst.done", done, 0);     chk("rst.err", err, 0);
    chk("rst.im_req", im_req, 0); chk("rst.dm_req", dm_req, 0);
    chk("rst.dm_we", dm_we, 0);   chk("rst.dm_addr", dm_addr, 0);
    chk("rst.dm_wdata", dm_wdata, 0);
    chk("rst.z", dbg_z, 0); chk("rst.n", dbg_n, 0); chk("rst.pc", dbg_pc, 0);

    // Basic program, zero wait states: 4 instructions x 2 cycles
    clear_imem(); im_wait = 0; dm_wait = 0;
    imem[0] = enc(OP_LDI, 4'd1, 4'd0, 20'd5);
    imem[1] = enc(OP_LDI, 4'd2, 4'd0, 20'd3);
    imem[2] = enc(OP_ADD, 4'd1, 4'd2, 20'd0);
    imem[3] = enc(OP_END, 4'd0, 4'd0, 20'd0);
    do_reset();
    start_and_wait(50, cyc);
    chk("t1.cycles", cyc, 8); chk("t1.done", done, 1);
    chk("t1.z", dbg_z, 0);    chk("t1.pc", dbg_pc, 3);
    imem[3] = enc(OP_ST, 4'd1, 4'd0, 20'd0);
    imem[4] = enc(OP_END, 4'd0, 4'd0, 20'd0);
    run_prog("t1b", 100, 1);
    chk("t1b.r1", (dm_log.size() > 0) ? dm_log[0].d : 8'hxx, 8'h08);

    // LD with 3 wait states
    clear_imem(); dm_wait = 3;
    tb_dm[20'h00010] = 8'hA7;
    imem[0] = enc(OP_LDI, 4'd3, 4'd0, 20'h10);
    imem[1] = enc(OP_LD,  4'd4, 4'd3, 20'd0);
    imem[2] = enc(OP_ST,  4'd4, 4'd0, 20'd0);
    imem[3] = enc(OP_SHR, 4'd4, 4'd0, 20'd8);
    run_prog("ld", 100, 1);
    chk("ld.req_len", (dm_len_q.size() > 0) ? dm_len_q[0] : -1, 4);
    chk("ld.data", (dm_log.size() > 1) ? dm_log[1].d : 8'hxx, 8'hA7);
    chk("ld.upper_zero", dbg_z, 1);

    // Single store, truncated to DATA_W
    clear_imem(); dm_wait = 0;
    imem[0] = enc(OP_LDI, 4'd5, 4'd0, 20'h1FF);
    imem[1] = enc(OP_LDI, 4'd6, 4'd0, 20'h20);
    imem[2] = enc(OP_ST,  4'd5, 4'd6, 20'd0);
    run_prog("st", 100, 1);
    chk("st.count", dm_log.size(), 1);
    chk("st.rec", (dm_log.size() > 0) ? dm_log[0] : 29'hx, {1'b1, 20'h00020, 8'hFF});

    // Downsample-style countdown loop with random fetch waits
    clear_imem(); im_wait = -1;
    imem[0] = enc(OP_LDI, 4'd1, 4'd0, 20'd4);
    imem[1] = enc(OP_LDI, 4'd7, 4'd0, 20'd1);
    imem[2] = enc(OP_LDI, 4'd2, 4'd0, 20'h80);
    imem[3] = enc(OP_SHR, 4'd2, 4'd0, 20'd1);
    imem[4] = enc(OP_SUB, 4'd1, 4'd7, 20'd0);
    imem[5] = enc(OP_JZ,  4'd1, 4'd0, 20'd7);
    imem[6] = enc(OP_JMP, 4'd0, 4'd0, 20'd3);
    imem[7] = enc(OP_END, 4'd0, 4'd0, 20'd0);
    run_prog("loop", 1000, 1);
    k = 0;
    foreach (fetch_log[i]) if (fetch_log[i] == 10'd3) k++;
    chk("loop.iters", k, 4); chk("loop.z", dbg_z, 1); chk("loop.exit_pc", dbg_pc, 7);

    // PC wrap from 1023 to 0
    clear_imem(); im_wait = 0;
    imem[0]    = enc(OP_JZ,  4'd1, 4'd0, 20'h3FF);
    imem[1023] = enc(OP_LDI, 4'd1, 4'd0, 20'h55);
    imem[1]    = enc(OP_ST,  4'd1, 4'd0, 20'd0);
    run_prog("wrap", 200, 1);
    chk("wrap.fetch", (fetch_log.size() > 2) ? fetch_log[2] : 10'hx, 10'd0);

    // Illegal opcode halts with err; later start ignored
    clear_imem();
    imem[0] = enc(OP_NOP, 4'd0, 4'd0, 20'd0);
    imem[1] = enc(4'hE, 4'd0, 4'd0, 20'd0);
    run_prog("ill", 100, 1);
    chk("ill.err", err, 1);
    reqs = 0;
    repeat (10) begin @(negedge clock); start = 1; if (im_req) reqs++; end
    start = 0;
    @(posedge clock); #1;
    chk("ill.no_req", reqs, 0); chk("ill.done_held", done, 1); chk("ill.pc_held", dbg_pc, 1);

    // Reset while a data access is outstanding
    clear_imem(); dm_wait = 1000;
    imem[0] = enc(OP_LDI, 4'd3, 4'd0, 20'h40);
    imem[1] = enc(OP_LD,  4'd4, 4'd3, 20'd0);
    do_reset();
    @(negedge clock); start = 1;
    @(posedge clock); #1 start = 0;
    k = 0;
    while (!dm_req && k < 50) begin @(posedge clock); #1; k++; end
    chk("mrst.req_seen", dm_req, 1);
    @(negedge clock); rst = 0;
    @(posedge clock); #1;
    chk("mrst.dm_req", dm_req, 0); chk("mrst.pc", dbg_pc, 0);
    chk("mrst.im_req", im_req, 0); chk("mrst.done", done, 0);
    @(negedge clock); rst = 1;
    repeat (3) @(posedge clock);
    #1 chk("mrst.idle", im_req, 0);
    dm_wait = 0; clear_imem();
    imem[0] = enc(OP_ST, 4'd3, 4'd3, 20'd0);
    run_prog("mrst.regs", 100, 0);

    // Random programs with random wait states
    im_wait = -1; dm_wait = -1;
    for (int t = 0; t < 25; t++) begin
      clear_imem();
      for (int a = 0; a < 32; a++) tb_dm[20'(a)] = 8'($urandom);
      len = $urandom_range(10, 20);
      for (int i = 0; i < len; i++) begin
        rd = 4'($urandom); rs = 4'($urandom);
        im = ($urandom_range(0, 1) != 0) ? 20'($urandom_range(0, 31)) : 20'($urandom);
        k = $urandom_range(0, 9);
        case (k)
          0: op = OP_LDI;  1: op = OP_ADD;  2: op = OP_SUB; 3: op = OP_SHR;
          4: op = OP_ADDI; 5: op = OP_LD;   6: op = OP_ST;
          7: begin op = OP_JZ; im = 20'(i + 2); end
          8: begin op = OP_JN; im = 20'(i + 2); end
          default: op = OP_NOP;
        endcase
        imem[i] = enc(op, rd, rs, im);
      end
      for (int j = 1; j < 8; j++) imem[len + j - 1] = enc(OP_ST, 4'(j), 4'd0, 20'd0);
      run_prog($sformatf("rnd%0d", t), 3000, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/param_dsp_core.md
Name: param_dsp_core

Overview:
- Parametrised successor of the fixed 8-bit downsampling processor: a multi-cycle register-file core for image downsampling with configurable data, address and PC widths and register count.
- Fetches 32-bit instructions from instruction memory and moves pixel data to and from data memory.
- Both memories use req/ack handshakes with arbitrary wait states, replacing fixed status-gated strobes.
- Sits between the top-level controller (start/done) and the IM/DM memory blocks.

Parameters:
- DATA_W, 8: DM data width.
- ADDR_W, 20: DM address width.
- PC_W, 10: IM address width.
- REG_W, 32: register and ALU width; must be >= ADDR_W and >= DATA_W.
- NREG, 8: number of registers, 2..16; R0 is hardwired to zero.

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  begin execution at PC=0 when idle.
- done  out  1  high while halted after END.
- err  out  1  sticky illegal-opcode flag.
- im_req  out  1  instruction fetch request.
- im_addr  out  PC_W  fetch address (current PC).
- im_ack  in  1  fetch complete; im_rdata valid this cycle.
- im_rdata  in  32  instruction word.
- dm_req  out  1  data access request.
- dm_we  out  1  1 = write, 0 = read; valid while dm_req.
- dm_addr  out  ADDR_W  data address.
- dm_wdata  out  DATA_W  write data.
- dm_ack  in  1  access complete; dm_rdata valid this cycle on reads.
- dm_rdata  in  DATA_W  read data.
- dbg_pc  out  PC_W  current PC.
- dbg_z  out  1  last ALU result == 0.
- dbg_n  out  1  last ALU result MSB.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, PC=0, all registers 0, IR=0.
  - done, err, im_req, dm_req, dm_we, dbg_z and dbg_n are 0; dm_addr and dm_wdata are 0.
  - Reset has priority over everything, including a pending handshake; any outstanding req is dropped the next cycle.
- Instruction format:
  - [31:28] opcode, [27:24] rd, [23:20] rs, [19:0] imm.
  - Register index >= NREG, or index 0: reads return 0 and writes are ignored.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd = zext(imm).
  - 2 LD: rd = zext(DM[R[rs][ADDR_W-1:0]]).
  - 3 ST: DM[R[rs][ADDR_W-1:0]] = R[rd][DATA_W-1:0].
  - 4 ADD: rd = rd + rs.
  - 5 SUB: rd = rd - rs.
  - 6 SHR: rd = rd >> imm[4:0], logical.
  - 7 ADDI: rd = rd + zext(imm).
  - 8 JMP: PC = imm[PC_W-1:0].
  - 9 JZ: if R[rd]==0 then PC = imm.
  - A JN: if R[rd][REG_W-1] then PC = imm.
  - B END.
  - C..F illegal.
- Arithmetic: modulo 2^REG_W, no carry out. dbg_z/dbg_n update only on opcodes 4..7.
- FSM states:
  - IDLE: wait for start=1, then go to FETCH with PC=0. start is ignored in all other states.
  - FETCH: im_req=1, im_addr=PC. On im_ack, latch IR=im_rdata and go to EXEC. im_req stays high until ack.
  - EXEC: one cycle.
    - ALU/LDI: write back, PC += 1, go to FETCH.
    - Jumps: update PC (taken) or PC += 1 (not taken), go to FETCH.
    - LD/ST: go to MEM.
    - END: go to HALT.
    - Illegal: set err, go to HALT.
  - MEM: dm_req=1, with dm_we/dm_addr/dm_wdata stable until ack. On dm_ack: LD writes rd=dm_rdata; PC += 1; go to FETCH.
  - HALT: done=1. done is held until reset; start has no effect.
- Handshake rules:
  - Ack may arrive in the same cycle req rises (zero-wait).
  - Ack while req=0 is ignored.
  - req deasserts the cycle after the accepted ack.
- Latency at zero wait:
  - ALU and jump instructions: 2 cycles (FETCH, EXEC).
  - LD/ST: 3 cycles.
- PC wraps modulo 2^PC_W: PC = 2^PC_W - 1 followed by a non-jump gives PC 0.

Decomposition:
- Shared package dsp_core_pkg holds:
  - opcode localparams OP_NOP..OP_END;
  - state encoding ST_IDLE, ST_FETCH, ST_EXEC, ST_MEM, ST_HALT;
  - instruction field bit positions.
- One sub-module, dsp_regfile (parameters NREG, REG_W):
  - 2 async read ports and 1 sync write port;
  - R0 and out-of-range indices read as 0; synchronous active-low clear.

Test Plan:
- Reset then start:
  - Program LDI R1,5; LDI R2,3; ADD R1,R2; END with zero-wait ack.
  - Required: R1=8, done=1 after 8 cycles, dbg_z=0.
- LD with 3 wait states:
  - DM[0x00010]=0xA7, R3=0x10, LD R4,R3.
  - Required: dm_req held exactly 4 cycles, then R4=0x000000A7.
- ST:
  - R5=0x1FF, R6=0x20, ST R5,R6.
  - Required: one DM write, dm_addr=0x00020, dm_wdata=0xFF, dm_we=1.
- Downsample loop:
  - Counter R1=4; loop body SHR then SUB R1,R7 (R7=1); JZ exit.
  - Required: exactly 4 iterations, dbg_z=1 at exit, final PC = exit target.
- Illegal opcode 0xE:
  - Required: err=1, done=1, no further im_req; a later start is ignored.
- Reset mid-MEM:
  - Drive rst=0 while dm_req=1 and no ack.
  - Required: next cycle dm_req=0, state IDLE, PC=0, registers 0.
